// File: rtl/johnson_pkg.sv
// Shared Johnson decade-code constants and helpers: stepping, legality, BCD decode
// and seven-segment encode.
package johnson_pkg;

  localparam int unsigned JC_W  = 5;
  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned SEL_W = 8;
  localparam int unsigned IDX_W = 4;

  localparam logic [JC_W-1:0]  JC_ZERO = 5'b00000;
  localparam logic [JC_W-1:0]  JC_NINE = 5'b10000;
  localparam logic [BCD_W-1:0] BCD_BAD = 4'hF;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  typedef logic [JC_W-1:0] jc_t;

  function automatic jc_t jc_step_up(input jc_t q);
    return {q[JC_W-2:0], ~q[JC_W-1]};
  endfunction

  function automatic jc_t jc_step_dn(input jc_t q);
    return {~q[0], q[JC_W-1:1]};
  endfunction

  function automatic logic jc_legal(input jc_t q);
    logic ok;
    case (q)
      5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
      5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: ok = 1'b1;
      default:                                           ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] jc_popcount(input jc_t q);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < int'(JC_W); i++) begin
      n = n + 3'(q[i]);
    end
    return n;
  endfunction

  // Lower half of the cycle fills with ones, upper half drains them.
  function automatic logic [BCD_W-1:0] jc_to_bcd(input jc_t q);
    logic [2:0] n;
    n = jc_popcount(q);
    if (!jc_legal(q)) begin
      return BCD_BAD;
    end
    if (!q[JC_W-1]) begin
      return {1'b0, n};
    end
    return 4'd10 - {1'b0, n};
  endfunction

  // Active-high segments, bit order g..a; non-decimal values blank.
  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] v);
    logic [SEG_W-1:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/johnson_digit.sv
// One 5-bit Johnson decade cell with load, step and terminal flags.
// JOHNSON_REPAIR_EN: an illegal code is cleared to zero on the next edge.
module johnson_digit
  import johnson_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            load,
  input  logic [JC_W-1:0] load_val,
  input  logic            step,
  input  logic            up,
  output logic [JC_W-1:0] code,
  output logic            is_zero,
  output logic            is_nine,
  output logic            legal
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      code <= JC_ZERO;
    end else if (load) begin
      code <= load_val;
`ifdef JOHNSON_REPAIR_EN
    end else if (!legal) begin
      code <= JC_ZERO;
`endif
    end else if (step) begin
      code <= up ? jc_step_up(code) : jc_step_dn(code);
    end
  end

  // Exact compares: an illegal code is never terminal, so it blocks the carry.
  assign is_zero = (code == JC_ZERO);
  assign is_nine = (code == JC_NINE);
  assign legal   = jc_legal(code);

endmodule

// File: rtl/johnson_bcd_counter.sv
// DIGITS-wide Johnson-code decade counter with carry chain, wrap flag and a
// registered digit-select view. Optional repair of illegal codes: JOHNSON_REPAIR_EN.
module johnson_bcd_counter
  import johnson_pkg::*;
#(
  parameter int unsigned DIGITS = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_up,
  input  logic                   i_load,
  input  logic [JC_W*DIGITS-1:0] i_init,
  input  logic [SEL_W-1:0]       i_sel,
  output logic [JC_W*DIGITS-1:0] o_digits,
  output logic [SEL_W-1:0]       o_cnt,
  output logic                   o_wrap
);

  logic [JC_W-1:0]   codes [DIGITS];
  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] is_nine;
  logic [DIGITS-1:0] unused_legal;
  logic [DIGITS:0]   carry;
  logic [JC_W-1:0]   sel_code;
  logic              sel_hit;
  logic [SEL_W-1:0]  cnt_next;
  logic [2:0]        unused_sel;

  assign carry[0]   = 1'b1;
  assign unused_sel = i_sel[6:4];

  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_digit
    // carry[k+1]: digits 0..k all terminal in the current direction
    assign carry[k+1] = carry[k] & (i_up ? is_nine[k] : is_zero[k]);

    johnson_digit u_digit (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .load     (i_load),
      .load_val (i_init[JC_W*k +: JC_W]),
      .step     (i_en & carry[k]),
      .up       (i_up),
      .code     (codes[k]),
      .is_zero  (is_zero[k]),
      .is_nine  (is_nine[k]),
      .legal    (unused_legal[k])
    );

    assign o_digits[JC_W*k +: JC_W] = codes[k];
  end

  // Digit-select mux; indices beyond DIGITS read as blank.
  always_comb begin
    sel_code = JC_ZERO;
    sel_hit  = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (i_sel[IDX_W-1:0] == IDX_W'(k)) begin
        sel_code = codes[k];
        sel_hit  = 1'b1;
      end
    end
    if (!sel_hit) begin
      cnt_next = '0;
    end else if (i_sel[SEL_W-1]) begin
      cnt_next = {1'b0, bcd_to_seg(jc_to_bcd(sel_code))};
    end else begin
      cnt_next = {3'b000, sel_code};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt  <= '0;
      o_wrap <= 1'b0;
    end else begin
      o_cnt  <= cnt_next;
      o_wrap <= !i_load && i_en && carry[DIGITS];
    end
  end

endmodule

// File: tb/tb_johnson_bcd_counter.sv
// Directed-vector bench for johnson_bcd_counter (DIGITS=12) with hand-computed expectations.
module tb_johnson_bcd_counter;

  localparam int unsigned N  = 12;
  localparam int unsigned DW = 5 * N;

  logic          clk;
  logic          rst;
  logic          en;
  logic          up;
  logic          load;
  logic [DW-1:0] init;
  logic [7:0]    sel;
  logic [DW-1:0] digits;
  logic [7:0]    cnt;
  logic          wrap;

  int vectors;
  int errors;

  johnson_bcd_counter #(.DIGITS(N)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_up     (up),
    .i_load   (load),
    .i_init   (init),
    .i_sel    (sel),
    .o_digits (digits),
    .o_cnt    (cnt),
    .o_wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference Johnson code table, value 0..9.
  function automatic logic [4:0] jc(input int v);
    logic [4:0] c;
    case (v)
      0: c = 5'b00000; 1: c = 5'b00001; 2: c = 5'b00011; 3: c = 5'b00111;
      4: c = 5'b01111; 5: c = 5'b11111; 6: c = 5'b11110; 7: c = 5'b11100;
      8: c = 5'b11000; 9: c = 5'b10000;
      default: c = 5'b00000;
    endcase
    return c;
  endfunction

  function automatic logic [4:0] dig(input int k);
    return digits[5*k +: 5];
  endfunction

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; init = '0; sel = 8'h00;

    // Reset state
    tick();
    check("rst_digits", 64'(digits), 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_wrap", 64'(wrap), 64'd0);

    // Count up 12 steps; o_cnt shows digit0 as it was before each edge
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      check("up_d0", 64'(dig(0)), 64'(jc(n % 10)));
      check("up_d1", 64'(dig(1)), (n >= 10) ? 64'h01 : 64'h00);
      check("up_cnt", 64'(cnt), 64'({3'b000, jc((n - 1) % 10)}));
      check("up_wrap", 64'(wrap), 64'd0);
    end

    // Full-range wrap upward
    en = 1'b0; load = 1'b1; init = {N{5'b10000}};
    tick();
    check("load_nines", 64'(digits), 64'({N{5'b10000}}));
    check("load_nowrap", 64'(wrap), 64'd0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    check("wrap_up_d", 64'(digits), 64'd0);
    check("wrap_up_flag", 64'(wrap), 64'd1);
    en = 1'b0;
    tick();
    check("wrap_up_clear", 64'(wrap), 64'd0);

    // Full-range wrap downward, then one more down step
    en = 1'b1; up = 1'b0;
    tick();
    check("wrap_dn_d", 64'(digits), 64'({N{5'b10000}}));
    check("wrap_dn_flag", 64'(wrap), 64'd1);
    tick();
    check("dn_step_d", 64'(digits), 64'({{(N-1){5'b10000}}, 5'b11000}));
    check("dn_step_wrap", 64'(wrap), 64'd0);

    // Select mux: digit3 = 7, others 0
    en = 1'b0; load = 1'b1; init = '0; init[19:15] = 5'b11100;
    tick();
    load = 1'b0; sel = 8'h83;
    tick();
    check("sel_83", 64'(cnt), 64'h07);
    sel = 8'h03;
    tick();
    check("sel_03", 64'(cnt), 64'h1C);
    sel = 8'h0F;
    tick();
    check("sel_0F", 64'(cnt), 64'h00);
    sel = 8'h8F;
    tick();
    check("sel_8F", 64'(cnt), 64'h00);
    sel = 8'h80;
    tick();
    check("sel_80", 64'(cnt), 64'h3F);
    sel = 8'hF3;
    tick();
    check("sel_F3", 64'(cnt), 64'h07);

    // Load beats step
    load = 1'b1; en = 1'b1; up = 1'b1; init = {N{5'b00001}};
    tick();
    check("load_en_d", 64'(digits), 64'({N{5'b00001}}));
    check("load_en_wrap", 64'(wrap), 64'd0);

    // Reset beats load
    rst = 1'b1; init = {N{5'b10000}};
    tick();
    check("rst_load_d", 64'(digits), 64'd0);
    check("rst_load_cnt", 64'(cnt), 64'd0);
    check("rst_load_wrap", 64'(wrap), 64'd0);

    // Reset suppresses a would-be wrap
    rst = 1'b0; load = 1'b1; en = 1'b0;
    tick();
    rst = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    check("rst_wrap_d", 64'(digits), 64'd0);
    check("rst_wrap_flag", 64'(wrap), 64'd0);

    // Illegal digit0 = 01010
    rst = 1'b0; en = 1'b0; load = 1'b1; init = '0; init[4:0] = 5'b01010;
    tick();
    check("ill_load", 64'(dig(0)), 64'h0A);
    load = 1'b0; sel = 8'h80;
    tick();
`ifdef JOHNSON_REPAIR_EN
    check("ill_repair_d0", 64'(dig(0)), 64'h00);
    check("ill_repair_seg", 64'(cnt), 64'h00);
    sel = 8'h00;
    tick();
    check("ill_repair_raw", 64'(cnt), 64'h00);
`else
    check("ill_hold_d0", 64'(dig(0)), 64'h0A);
    check("ill_hold_seg", 64'(cnt), 64'h00);
    en = 1'b1; up = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      check("ill_step_d0", 64'(dig(0)), (n % 2 == 1) ? 64'h15 : 64'h0A);
      check("ill_step_d1", 64'(dig(1)), 64'h00);
      check("ill_step_seg", 64'(cnt), 64'h00);
      check("ill_step_wrap", 64'(wrap), 64'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/johnson_bcd_counter.md
# johnson_bcd_counter

Parametrised successor to the fixed 12-digit Johnson-code decade counter: a DIGITS-wide cascade of 5-bit Johnson decade cells with enable, up/down direction, parallel load, registered wrap flag and a registered digit-select output port. Sits directly behind the tile I/O wrapper; the select bus comes from the input pins and the 8-bit result drives the output pins.

## Interface

- DIGITS, 12, number of decade cells (1..16)
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset: one clock; reset is synchronous and active-high
- i_en  in  1  count enable, one step per cycle
- i_up  in  1  direction: 1 = increment, 0 = decrement
- i_load  in  1  parallel load of i_init
- i_init  in  5*DIGITS  load value, digit k at bits [5k+4:5k], digit 0 least significant
- i_sel  in  8  [3:0] digit index, [7] output mode (0 raw Johnson, 1 seven-segment), [6:4] ignored
- o_digits  out  5*DIGITS  current Johnson code of every digit
- o_cnt  out  8  registered selected-digit view
- o_wrap  out  1  registered full-range wrap pulse

## Operation

- Johnson code, value 0..9: 00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000. Other 22 codes illegal.
- Step up: q <= {q[3:0], ~q[4]}; step down: q <= {~q[0], q[4:1]}. Single-bit change per step, 9->0 and 0->9 included.
- Decode: q[4]==0 -> value = popcount(q); q[4]==1 -> value = 10 - popcount(q); illegal -> 4'hF.
- Priority per cycle: i_rst > i_load > i_en > hold.
- Digit k steps when i_en and every digit j<k is terminal (9 when up, 0 when down). Digit 0 steps whenever i_en.
- i_up sampled each cycle; direction change takes effect on the same edge, no pipeline.
- o_wrap: 1 for one cycle after an enabled step in which all digits were terminal (99..9 -> 00..0 up, 00..0 -> 99..9 down). Not set by load or reset.
- o_cnt, index < DIGITS: mode 0 = {3'b000, code}; mode 1 = {1'b0, segments g..a} of decoded value, active-high, illegal -> 7'h00.
- o_cnt, index >= DIGITS: 8'h00 in both modes.

## Timing

- Reset values: o_digits all 00000, o_cnt 8'h00, o_wrap 0.
- o_digits: registered, updates on the edge where load/step is sampled.
- o_cnt: one cycle behind o_digits/i_sel (computed from post-edge digit state of the previous cycle's registers, i.e. reflects o_digits as they were before the current edge, with i_sel sampled at that edge).
- o_wrap: asserted the cycle after the wrapping edge, cleared next cycle unless wrapping again (DIGITS=1 up-counting continuously: pulse every 10 cycles).
- i_rst mid-count or with i_load/i_en: reset wins, o_wrap forced 0 that edge.
- i_load with i_en: load wins, no step, no wrap.
- Illegal digit, no repair: stepping rule still applied; digit never counts as terminal, so it blocks carry to higher digits.

## Configuration

- JOHNSON_REPAIR_EN defined: any digit holding an illegal code is forced to 00000 on the next edge regardless of i_en (load and reset still take priority); that edge does not propagate carry from it and does not set o_wrap.
- Undefined: no repair; illegal codes persist/shift per the step rule. Decode still reports 4'hF / blank segments.

## Structure

- johnson_pkg: JC_W = 5, JC_ZERO, JC_NINE, jc_step_up, jc_step_dn, jc_to_bcd, bcd_to_seg functions.
- Sub-module johnson_digit: one cell with i_clk, i_rst, load, load value, step, up; outputs code, is_zero, is_nine, legal. Top generates DIGITS instances, carry chain, select mux, o_wrap register.

## Test plan

- Reset, DIGITS=12, i_en=1 i_up=1 for 12 cycles -> digit0 00000->...->10000->00000->00011; digit1 00001 after cycle 10; o_cnt tracks one cycle behind.
- Load all digits 10000 (999..9), i_en=1 up -> next edge all 00000, o_wrap=1 for exactly one cycle.
- All zero, i_up=0, i_en=1 -> all 10000, o_wrap pulse; further step -> digit0 11000, others stay 10000.
- i_sel=8'h83 with digit3 = 11100 -> o_cnt = 8'h07 (seven-seg "7"); i_sel=8'h03 -> 8'h1C; i_sel=8'h0F with DIGITS=12 -> 8'h00.
- i_load and i_en together, then i_rst with i_load -> load wins over step; reset wins over load, outputs zero, o_wrap 0.
- Load digit0 = 01010: with JOHNSON_REPAIR_EN, i_en=0 -> 00000 next edge, o_cnt raw 8'h00 after; without -> holds 01010, mode-1 o_cnt 8'h00, digit1 never carries with i_en=1.
